// File: rtl/npc_bpred.sv
// Fetch-PC unit: PC register, next-PC priority mux, and optional bimodal BHT of
// 2-bit counters. Define NPC_BHT_EN to build the BHT; otherwise branches are
// statically predicted not-taken.
module npc_bpred #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          BHT_DEPTH = 64,
  localparam int         BHT_IDX_W = $clog2(BHT_DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        if_is_branch,
  input  logic [31:0] if_offset,
  input  logic        if_is_jump,
  input  logic [25:0] if_imm26,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic        res_pred_taken,
  input  logic [31:0] res_target,
  input  logic        jr_valid,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pred_taken,
  output logic        flush
);

  logic [31:0] pc_q, pc_d;
  logic        mispredict;
  logic [31:0] jr_tgt_al;
  logic [31:0] res_tgt_al;
  logic [31:0] res_fall;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;

  assign jr_tgt_al  = jr_target  & 32'hFFFF_FFFC;
  assign res_tgt_al = res_target & 32'hFFFF_FFFC;
  assign res_fall   = (res_pc & 32'hFFFF_FFFC) + 32'd4;

  assign mispredict = res_valid & (res_taken != res_pred_taken);
  assign flush      = ~reset & (jr_valid | mispredict);

`ifdef NPC_BHT_EN
  logic [1:0]           bht_q [BHT_DEPTH];
  logic [BHT_IDX_W-1:0] rd_idx;
  logic [BHT_IDX_W-1:0] wr_idx;

  assign rd_idx = pc_q[BHT_IDX_W+1:2];
  assign wr_idx = res_pc[BHT_IDX_W+1:2];

  // Lookup reads the registered counter, so a same-cycle update is not bypassed.
  assign pred_taken = if_is_branch & bht_q[rd_idx][1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
    end else if (res_valid) begin
      if (res_taken) begin
        if (bht_q[wr_idx] != 2'b11) bht_q[wr_idx] <= bht_q[wr_idx] + 2'b01;
      end else begin
        if (bht_q[wr_idx] != 2'b00) bht_q[wr_idx] <= bht_q[wr_idx] - 2'b01;
      end
    end
  end
`else
  assign pred_taken = 1'b0;
`endif

  always_comb begin
    pc_d = pc_plus4;
    if (reset) begin
      pc_d = RESET_PC;
    end else if (jr_valid) begin
      pc_d = jr_tgt_al;
    end else if (mispredict) begin
      pc_d = res_taken ? res_tgt_al : res_fall;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (if_is_jump) begin
      pc_d = {pc_plus4[31:28], if_imm26, 2'b00};
    end else if (pred_taken) begin
      pc_d = pc_plus4 + (if_offset << 2);
    end
  end

  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

endmodule

// File: tb/tb_npc_bpred.sv
// Directed bench for npc_bpred: reset, sequential fetch, jump, BHT training,
// mispredict/jr redirects, stall, reset mid-stall and PC wrap.
module tb_npc_bpred;

`ifdef NPC_BHT_EN
  localparam bit BHT = 1'b1;
`else
  localparam bit BHT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        if_is_branch;
  logic [31:0] if_offset;
  logic        if_is_jump;
  logic [25:0] if_imm26;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic        res_pred_taken;
  logic [31:0] res_target;
  logic        jr_valid;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pred_taken;
  logic        flush;

  int n_checks = 0;
  int n_errors = 0;

  npc_bpred dut (
    .clk(clk), .reset(reset), .stall(stall),
    .if_is_branch(if_is_branch), .if_offset(if_offset),
    .if_is_jump(if_is_jump), .if_imm26(if_imm26),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .res_pred_taken(res_pred_taken), .res_target(res_target),
    .jr_valid(jr_valid), .jr_target(jr_target),
    .pc(pc), .pc_plus4(pc_plus4), .pred_taken(pred_taken), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; if_is_branch = 0; if_offset = 0; if_is_jump = 0; if_imm26 = 0;
    res_valid = 0; res_pc = 0; res_taken = 0; res_pred_taken = 0; res_target = 0;
    jr_valid = 0; jr_target = 0;
  endtask

  task automatic resolve(input logic [31:0] rpc, input logic taken, input logic ptaken,
                         input logic [31:0] tgt);
    res_valid = 1; res_pc = rpc; res_taken = taken; res_pred_taken = ptaken; res_target = tgt;
  endtask

  task automatic jr_to(input logic [31:0] tgt);
    jr_valid = 1; jr_target = tgt;
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    #1;
    check("flush_in_reset", {31'd0, flush}, 32'd0);
    tick();
    check("pred_in_reset", {31'd0, pred_taken}, 32'd0);
    tick();
    check("pc_reset", pc, 32'h0000_3000);
    reset = 0;
    #1;
    check("flush_after_reset", {31'd0, flush}, 32'd0);
    check("pc_plus4_reset", pc_plus4, 32'h0000_3004);
    tick();
    check("pc_seq1", pc, 32'h0000_3004);
    tick();
    check("pc_seq2", pc, 32'h0000_3008);

    // Direct jump from IF
    if_is_jump = 1; if_imm26 = 26'h0000C10;
    #1;
    check("jump_flush", {31'd0, flush}, 32'd0);
    tick();
    idle_inputs();
    check("jump_pc", pc, 32'h0000_3040);

    // Train index 4 taken twice: 01 -> 10 -> 11
    resolve(32'h0000_3010, 1, 1, 32'h0000_3100);
    #1;
    check("train_no_flush", {31'd0, flush}, 32'd0);
    tick();
    tick();
    idle_inputs();
    check("train_pc_seq", pc, 32'h0000_3048);
    jr_to(32'h0000_3010);
    check("jr_to_3010", pc, 32'h0000_3010);
    if_is_branch = 1; if_offset = 32'd4;
    #1;
    check("pred_trained", {31'd0, pred_taken}, {31'd0, BHT});
    tick();
    idle_inputs();
    check("pred_next_pc", pc, BHT ? 32'h0000_3024 : 32'h0000_3014);

    // Mispredict not-taken: fall through, counter 11 -> 10
    resolve(32'h0000_3010, 0, 1, 32'h0000_3100);
    #1;
    check("mispred_flush", {31'd0, flush}, 32'd1);
    tick();
    check("mispred_pc", pc, 32'h0000_3014);
    // Same with jr: jr wins, counter 10 -> 01
    jr_valid = 1; jr_target = 32'h0000_3100;
    #1;
    check("jr_mispred_flush", {31'd0, flush}, 32'd1);
    tick();
    idle_inputs();
    check("jr_mispred_pc", pc, 32'h0000_3100);
    jr_to(32'h0000_3010);
    if_is_branch = 1; if_offset = 32'd4;
    #1;
    check("pred_after_decr", {31'd0, pred_taken}, 32'd0);
    tick();
    idle_inputs();
    check("pred_after_decr_pc", pc, 32'h0000_3014);

    // Stall holds PC over a jump; jr in the third stalled cycle redirects
    jr_to(32'h0000_3020);
    stall = 1; if_is_jump = 1; if_imm26 = 26'h0000123;
    tick();
    check("stall_hold1", pc, 32'h0000_3020);
    #1;
    check("stall_no_flush", {31'd0, flush}, 32'd0);
    tick();
    check("stall_hold2", pc, 32'h0000_3020);
    jr_valid = 1; jr_target = 32'h0000_3203;
    #1;
    check("stall_jr_flush", {31'd0, flush}, 32'd1);
    tick();
    idle_inputs();
    check("stall_jr_pc", pc, 32'h0000_3200);

    // Retrain index 4 to 11, then reset mid-stall with redirects pending
    resolve(32'h0000_3010, 1, 1, 32'h0000_3100);
    tick();
    tick();
    idle_inputs();
    jr_to(32'h0000_3010);
    if_is_branch = 1; if_offset = 32'd4;
    #1;
    check("pred_retrained", {31'd0, pred_taken}, {31'd0, BHT});
    stall = 1;
    tick();
    check("stall_at_3010", pc, 32'h0000_3010);
    reset = 1; jr_valid = 1; jr_target = 32'h0000_3400;
    resolve(32'h0000_3010, 1, 0, 32'h0000_3500);
    #1;
    check("reset_kills_flush", {31'd0, flush}, 32'd0);
    tick();
    reset = 0;
    idle_inputs();
    check("reset_mid_stall_pc", pc, 32'h0000_3000);
    jr_to(32'h0000_3010);
    if_is_branch = 1; if_offset = 32'd4;
    #1;
    check("pred_after_reset", {31'd0, pred_taken}, 32'd0);
    tick();
    idle_inputs();
    check("pred_after_reset_pc", pc, 32'h0000_3014);

    // PC wrap
    jr_to(32'hFFFF_FFFC);
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'h0000_0000);
    tick();
    check("wrap_next", pc, 32'h0000_0000);

    // Mispredict taken redirects to aligned resolved target
    resolve(32'h0000_3050, 1, 0, 32'h0000_3401);
    #1;
    check("mispred_taken_flush", {31'd0, flush}, 32'd1);
    tick();
    idle_inputs();
    check("mispred_taken_pc", pc, 32'h0000_3400);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/npc_bpred.md
Name: npc_bpred

Overview:
- Next-generation fetch-PC unit for the 5-stage MIPS32 pipeline: holds the PC register and selects the next fetch address.
- Adds stall handling, IF-stage direct-jump redirect, and late-resolution redirect (branch mispredict, jr).
- Adds a parametrised bimodal branch-history table (BHT) of 2-bit saturating counters.
- Sits in IF; resolution inputs come from the branch-compare stage (D).

Parameters:
- RESET_PC, 32'h0000_3000, fetch address after reset.
- BHT_DEPTH, 64, number of BHT entries; power of two, range 4..1024.
- BHT_IDX_W, $clog2(BHT_DEPTH), BHT index width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  freeze PC (hazard unit)
- if_is_branch  input  1  IF instruction is a conditional branch (beq family)
- if_offset  input  32  sign-extended 16-bit branch offset of the IF instruction
- if_is_jump  input  1  IF instruction is j/jal
- if_imm26  input  26  jump index of the IF instruction
- res_valid  input  1  a conditional branch resolves this cycle
- res_pc  input  32  PC of the resolving branch
- res_taken  input  1  actual outcome
- res_pred_taken  input  1  prediction carried down the pipe with that branch
- res_target  input  32  resolved taken target
- jr_valid  input  1  jr/jalr resolves this cycle
- jr_target  input  32  register target
- pc  output  32  current fetch address
- pc_plus4  output  32  pc+4
- pred_taken  output  1  prediction for the IF instruction
- flush  output  1  kill the instruction in IF (redirect from resolution)

Behaviour:
- The PC register is the only PC state. pc and pc_plus4 are combinational from it. pc[1:0] is always 2'b00; bits [1:0] of jr_target and res_target are forced to 0.
- Reset (synchronous): pc <= RESET_PC and all BHT counters <= 2'b01 (weakly not-taken), in the same edge. Reset overrides every other input, including a mid-stall or mid-redirect state.
- During reset and the cycle after: flush=0; pred_taken reflects counters at 01, so it is 0.
- BHT index = pc[BHT_IDX_W+1:2] for lookup and res_pc[BHT_IDX_W+1:2] for update.
- pred_taken = if_is_branch & counter[idx][1]; combinational, no added latency.
- mispredict = res_valid & (res_taken != res_pred_taken).
- Next-PC priority, highest first:
  1. reset -> RESET_PC
  2. jr_valid -> jr_target
  3. mispredict -> res_taken ? res_target : res_pc+4
  4. stall -> pc (hold)
  5. if_is_jump -> {pc_plus4[31:28], if_imm26, 2'b00}
  6. pred_taken -> pc_plus4 + (if_offset<<2), 32-bit wrap
  7. otherwise pc_plus4 (wraps 0xFFFFFFFC -> 0x00000000)
- flush = ~reset & (jr_valid | mispredict). Combinational, same cycle as the redirect. Redirects win over stall.
- jr_valid and mispredict in the same cycle: jr wins, flush=1. The BHT still updates for res_valid.
- BHT update on res_valid & ~reset, at the clock edge, independent of stall:
  - res_taken: counter saturating increment (11 stays 11).
  - otherwise: saturating decrement (00 stays 00).
- Same-index read and update in one cycle: lookup returns the pre-update value (no bypass).
- Aliasing between branches sharing an index is permitted; no tags.

Optional Feature:
- NPC_BHT_EN defined: BHT instantiated as described.
- NPC_BHT_EN undefined: no counter storage. pred_taken is tied to 0 (static not-taken), so priority level 6 never fires. Mispredict and redirect logic are unchanged, so taken branches always redirect via level 3. Ports are identical in both builds.

Test Plan:
- Reset held 2 cycles, then no control inputs -> pc = 0x3000, 0x3004, 0x3008 on consecutive cycles; flush=0, pred_taken=0.
- pc=0x3008, if_is_jump=1, if_imm26=0x0000C10 -> next pc=0x00003040, flush=0.
- Two res_valid with res_taken=1, res_pc=0x3010 (counter 01->10->11); later fetch 0x3010 with if_is_branch=1, if_offset=4 -> pred_taken=1, next pc=0x3024. With NPC_BHT_EN undefined: pred_taken=0, next pc=0x3014.
- res_valid, res_pc=0x3010, res_pred_taken=1, res_taken=0 -> flush=1 same cycle, next pc=0x3014, counter 11->10; repeat with jr_valid=1, jr_target=0x3100 -> next pc=0x3100.
- stall=1 for 3 cycles at pc=0x3020 with if_is_jump=1 -> pc holds 0x3020; on the third cycle jr_valid=1, jr_target=0x3203 -> next pc=0x3200, flush=1.
- Counters at 11, reset asserted mid-stall -> pc=0x3000 and the index-4 (0x3010) counter returns to 01, so pred_taken=0 on its next fetch.
